// File: rtl/time_set_buttons.sv
// ---------------------------------------------------------------------------
// time_set_buttons
//
// Front-end for the time-keeping counter. It turns the raw Minutes and Hours
// push-buttons into clean one-cycle increment strobes, with auto-repeat while
// a button is held. The counter downstream only ever sees single-cycle
// strobes, and never sees both strobes in the same cycle.
//
// Processing chain, per button:
//   raw input -> 2-flop synchroniser -> debounce filter -> arming guard
//             -> IDLE/PRESSED/REPEAT FSM -> shared registered output stage
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a new level
//   HOLD_CYCLES     : hold time after the first strobe before auto-repeat
//   REPEAT_CYCLES   : cycles between auto-repeat strobes (must be >= 4)
//
// Ports:
//   Clk_100M        in   system clock
//   Reset           in   asynchronous, active-high reset
//   Button_Minutes  in   raw minutes button, active-high, asynchronous
//   Button_Hours    in   raw hours button, active-high, asynchronous
//   Set_Enable      in   time-set mode slide switch, asynchronous
//   Set_Minutes     out  one-cycle minutes increment strobe
//   Set_Hours       out  one-cycle hours increment strobe
//   Repeat_Active   out  [1]=hours, [0]=minutes channel is auto-repeating
//
// Optional build macro:
//   TIME_SET_ACCEL_EN : when defined, each channel counts its auto-repeat
//                       strobes (4-bit, saturating); after 8 of them the
//                       repeat interval drops to REPEAT_CYCLES/4. When not
//                       defined the interval is always REPEAT_CYCLES and no
//                       repeat counter exists.
// ---------------------------------------------------------------------------
module time_set_buttons #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic       Button_Minutes,
    input  logic       Button_Hours,
    input  logic       Set_Enable,
    output logic       Set_Minutes,
    output logic       Set_Hours,
    output logic [1:0] Repeat_Active
);

    // Channel index 0 is minutes, channel index 1 is hours throughout.
    localparam int NUM_CH    = 2;
    localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX) + 1;
    localparam int DW        = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
`ifdef TIME_SET_ACCEL_EN
    localparam logic [TW-1:0] FAST_LAST   = TW'((REPEAT_CYCLES / 4) - 1);
    localparam logic [3:0]    ACCEL_AFTER = 4'd8;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } chanState_t;

    // Synchroniser stages, bit order {enable, hours, minutes}.
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    w_rawIn;
    logic [1:0]    w_btnSync;
    logic          w_enSync;

    // Debounce state.
    logic [DW-1:0] r_debCnt [NUM_CH];
    logic [1:0]    r_stable;

    // Arming guard.
    logic [1:0]    r_armed;

    // Channel FSMs and their timers.
    chanState_t    r_state      [NUM_CH];
    chanState_t    w_nextState  [NUM_CH];
    logic [TW-1:0] r_timer      [NUM_CH];
    logic [TW-1:0] w_nextTimer  [NUM_CH];
    logic [TW-1:0] w_repeatLast [NUM_CH];
    logic [1:0]    w_req;

`ifdef TIME_SET_ACCEL_EN
    logic [3:0]    r_repCount     [NUM_CH];
    logic [3:0]    w_nextRepCount [NUM_CH];
`endif

    // Output stage.
    logic          r_setMinutes;
    logic          r_setHours;
    logic          r_pending;
    logic [1:0]    r_repeatActive;
    logic          w_minWant;

    assign w_rawIn   = {Set_Enable, Button_Hours, Button_Minutes};
    assign w_btnSync = r_sync2[1:0];
    assign w_enSync  = r_sync2[2];

    // Two-flop synchronisers for all three asynchronous inputs. Nothing
    // downstream looks at the raw pins.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_rawIn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce filter. The counter only runs while the synchronised level
    // disagrees with the accepted level, and any agreement restarts it, so a
    // disagreement has to persist for DEBOUNCE_CYCLES consecutive cycles
    // before the accepted level flips.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_debCnt[i] <= '0;
            end
            r_stable <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_btnSync[i] == r_stable[i]) begin
                    r_debCnt[i] <= '0;
                end else if (r_debCnt[i] == DEB_LAST) begin
                    r_stable[i] <= w_btnSync[i];
                    r_debCnt[i] <= '0;
                end else begin
                    r_debCnt[i] <= r_debCnt[i] + 1'b1;
                end
            end
        end
    end

    // Arming guard. A channel may only fire after the button has genuinely
    // been seen released while set mode is on. The synchronised level is
    // required to be 0 as well as the accepted level, because the accepted
    // level starts at 0 out of reset and would otherwise arm a button that
    // is being held through reset release. The enable and button
    // synchronisers fill on the same edge, so the first enabled cycle
    // already sees the real button level. Dropping set mode disarms, which
    // forces a release and re-press after set mode is turned back on.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            r_armed <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_enSync) begin
                    r_armed[i] <= 1'b0;
                end else if (!r_stable[i] && !w_btnSync[i]) begin
                    r_armed[i] <= 1'b1;
                end
            end
        end
    end

    // Terminal count for the auto-repeat interval. With acceleration the
    // interval shortens once enough repeat strobes have been issued.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_repeatLast[i] = REPEAT_LAST;
`ifdef TIME_SET_ACCEL_EN
            if (r_repCount[i] >= ACCEL_AFTER) begin
                w_repeatLast[i] = FAST_LAST;
            end
`endif
        end
    end

    // Channel FSM state, timer and (optional) repeat counter registers.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_timer[i] <= '0;
`ifdef TIME_SET_ACCEL_EN
                r_repCount[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_nextState[i];
                r_timer[i] <= w_nextTimer[i];
`ifdef TIME_SET_ACCEL_EN
                r_repCount[i] <= w_nextRepCount[i];
`endif
            end
        end
    end

    // Channel FSM next-state logic. A request is raised on the first press
    // (IDLE->PRESSED), when the hold time expires (PRESSED->REPEAT) and at
    // every repeat interval in REPEAT. The timer is cleared on every request
    // and on every return to IDLE, so it never needs to saturate. With set
    // mode off everything is parked in IDLE and no request is raised.
    always_comb begin
        w_nextState = r_state;
        w_nextTimer = r_timer;
        w_req       = '0;
`ifdef TIME_SET_ACCEL_EN
        w_nextRepCount = r_repCount;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_enSync) begin
                w_nextState[i] = ST_IDLE;
                w_nextTimer[i] = '0;
`ifdef TIME_SET_ACCEL_EN
                w_nextRepCount[i] = '0;
`endif
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        w_nextTimer[i] = '0;
`ifdef TIME_SET_ACCEL_EN
                        w_nextRepCount[i] = '0;
`endif
                        if (r_stable[i] && r_armed[i]) begin
                            w_req[i]       = 1'b1;
                            w_nextState[i] = ST_PRESSED;
                        end
                    end
                    ST_PRESSED: begin
                        if (!r_stable[i]) begin
                            w_nextState[i] = ST_IDLE;
                            w_nextTimer[i] = '0;
                        end else if (r_timer[i] == HOLD_LAST) begin
                            w_req[i]       = 1'b1;
                            w_nextTimer[i] = '0;
                            w_nextState[i] = ST_REPEAT;
                        end else begin
                            w_nextTimer[i] = r_timer[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!r_stable[i]) begin
                            w_nextState[i] = ST_IDLE;
                            w_nextTimer[i] = '0;
`ifdef TIME_SET_ACCEL_EN
                            w_nextRepCount[i] = '0;
`endif
                        end else if (r_timer[i] == w_repeatLast[i]) begin
                            w_req[i]       = 1'b1;
                            w_nextTimer[i] = '0;
`ifdef TIME_SET_ACCEL_EN
                            if (r_repCount[i] != 4'hF) begin
                                w_nextRepCount[i] = r_repCount[i] + 1'b1;
                            end
`endif
                        end else begin
                            w_nextTimer[i] = r_timer[i] + 1'b1;
                        end
                    end
                    default: begin
                        w_nextState[i] = ST_IDLE;
                        w_nextTimer[i] = '0;
                    end
                endcase
            end
        end
    end

    // A minutes strobe is wanted for a fresh minutes request or a deferred
    // one. Both collapse into a single strobe when they coincide. A deferred
    // request is dropped as soon as set mode is switched off.
    assign w_minWant = w_req[0] | (r_pending & w_enSync);

    // Registered output stage. Hours has priority on a collision; the
    // minutes strobe is deferred by exactly one cycle through r_pending, so
    // the two strobes are never high together. Repeat_Active mirrors the
    // registered FSM state one cycle later.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            r_setMinutes   <= 1'b0;
            r_setHours     <= 1'b0;
            r_pending      <= 1'b0;
            r_repeatActive <= '0;
        end else begin
            if (w_req[1]) begin
                r_setHours   <= 1'b1;
                r_setMinutes <= 1'b0;
                r_pending    <= w_minWant;
            end else begin
                r_setHours   <= 1'b0;
                r_setMinutes <= w_minWant;
                r_pending    <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_repeatActive[i] <= (r_state[i] == ST_REPEAT);
            end
        end
    end

    assign Set_Minutes   = r_setMinutes;
    assign Set_Hours     = r_setHours;
    assign Repeat_Active = r_repeatActive;

endmodule

// File: tb/tb_time_set_buttons.sv
// ---------------------------------------------------------------------------
// tb_time_set_buttons
//
// Directed bench for time_set_buttons with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20,
// REPEAT_CYCLES=8. Times are counted in clock edges relative to a test
// start: edge 1 is the first edge that samples the new raw input level, so a
// clean press yields its strobe on edge 7 (2 synchroniser edges, 4 debounce
// edges, 1 output register edge).
// ---------------------------------------------------------------------------
module tb_time_set_buttons;

    localparam int DEB = 4;
    localparam int HLD = 20;
    localparam int RPT = 8;

    logic       Clk_100M       = 1'b0;
    logic       Reset          = 1'b1;
    logic       Button_Minutes = 1'b0;
    logic       Button_Hours   = 1'b0;
    logic       Set_Enable     = 1'b0;
    logic       Set_Minutes;
    logic       Set_Hours;
    logic [1:0] Repeat_Active;

    int   assertCount   = 0;
    int   failCount     = 0;
    int   edgeCount     = 0;
    int   tBase         = 0;
    int   qMin[$];
    int   qHr[$];
    logic collisionSeen = 1'b0;
    logic repeatSeen    = 1'b0;

    time_set_buttons #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HLD),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .Clk_100M       (Clk_100M),
        .Reset          (Reset),
        .Button_Minutes (Button_Minutes),
        .Button_Hours   (Button_Hours),
        .Set_Enable     (Set_Enable),
        .Set_Minutes    (Set_Minutes),
        .Set_Hours      (Set_Hours),
        .Repeat_Active  (Repeat_Active)
    );

    // 100 MHz clock.
    always #5 Clk_100M = ~Clk_100M;

    // Free-running edge counter used as the time base.
    always @(posedge Clk_100M) edgeCount <= edgeCount + 1;

    // Record strobes (as relative edge numbers) and sticky observations,
    // sampled half a cycle away from the active edge.
    always @(negedge Clk_100M) begin
        if (Set_Minutes === 1'b1) qMin.push_back(edgeCount - tBase);
        if (Set_Hours === 1'b1) qHr.push_back(edgeCount - tBase);
        if (Set_Minutes === 1'b1 && Set_Hours === 1'b1) collisionSeen = 1'b1;
        if (Repeat_Active !== 2'b00) repeatSeen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic minutes, input logic hours, input logic enable);
        Button_Minutes = minutes;
        Button_Hours   = hours;
        Set_Enable     = enable;
    endtask

    // Advance n clock edges and settle 2 ns past the last one.
    task automatic nextEdge(input int n);
        repeat (n) @(posedge Clk_100M);
        #2;
    endtask

    // Start a new relative time base and clear the recorders. Called 2 ns
    // after an edge, so the next edge is relative edge 1.
    task automatic startTest();
        tBase         = edgeCount;
        qMin.delete();
        qHr.delete();
        repeatSeen    = 1'b0;
    endtask

    // Move to 2 ns after relative edge r.
    task automatic toRel(input int r);
        int n;
        n = tBase + r - edgeCount;
        if (n > 0) nextEdge(n);
    endtask

    function automatic int qAt(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    initial begin
        int expHr3[6];
        int expHr6[12];
        expHr3 = '{7, 27, 35, 43, 51, 59};
        expHr6 = '{7, 27, 35, 43, 51, 59, 67, 75, 83, 91, 93, 95};

        // Reset, then release with set mode on.
        applyStimulus(1'b0, 1'b0, 1'b1);
        nextEdge(3);
        Reset = 1'b0;
        checkOutput("reset Set_Minutes", {31'd0, Set_Minutes}, 0);
        checkOutput("reset Set_Hours", {31'd0, Set_Hours}, 0);
        checkOutput("reset Repeat_Active", {30'd0, Repeat_Active}, 0);
        nextEdge(6);

        // 1: short minutes press gives exactly one strobe at edge 7.
        $display("[TB] test 1: single minutes press");
        startTest();
        applyStimulus(1'b1, 1'b0, 1'b1);
        nextEdge(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        toRel(20);
        checkOutput("t1 min count", qMin.size(), 1);
        checkOutput("t1 min edge", qAt(qMin, 0), 7);
        checkOutput("t1 hr count", qHr.size(), 0);
        checkOutput("t1 repeat idle", {31'd0, repeatSeen}, 0);

        // 2: 3-cycle hours glitch is filtered out.
        $display("[TB] test 2: hours glitch");
        startTest();
        applyStimulus(1'b0, 1'b1, 1'b1);
        nextEdge(3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        toRel(15);
        checkOutput("t2 hr count", qHr.size(), 0);
        checkOutput("t2 min count", qMin.size(), 0);

        // 3: hours held 60 edges: hold then auto-repeat.
        $display("[TB] test 3: hours hold and repeat");
        startTest();
        applyStimulus(1'b0, 1'b1, 1'b1);
        toRel(27);
        checkOutput("t3 repeat before", {30'd0, Repeat_Active}, 0);
        toRel(28);
        checkOutput("t3 repeat on", {30'd0, Repeat_Active}, 2);
        toRel(60);
        applyStimulus(1'b0, 1'b0, 1'b1);
        toRel(67);
        checkOutput("t3 repeat held", {30'd0, Repeat_Active}, 2);
        toRel(68);
        checkOutput("t3 repeat off", {30'd0, Repeat_Active}, 0);
        toRel(75);
        checkOutput("t3 hr count", qHr.size(), 6);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("t3 hr pulse %0d", k), qAt(qHr, k), expHr3[k]);
        end
        checkOutput("t3 min count", qMin.size(), 0);

        // 4: simultaneous rise, hours first then minutes.
        $display("[TB] test 4: collision");
        startTest();
        applyStimulus(1'b1, 1'b1, 1'b1);
        nextEdge(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        toRel(20);
        checkOutput("t4 hr count", qHr.size(), 1);
        checkOutput("t4 hr edge", qAt(qHr, 0), 7);
        checkOutput("t4 min count", qMin.size(), 1);
        checkOutput("t4 min edge", qAt(qMin, 0), 8);

        // 5: reset mid-REPEAT, button kept held through reset release.
        $display("[TB] test 5: reset during hold");
        startTest();
        applyStimulus(1'b1, 1'b0, 1'b1);
        toRel(35);
        checkOutput("t5 strobe before reset", {31'd0, Set_Minutes}, 1);
        checkOutput("t5 repeat before reset", {30'd0, Repeat_Active}, 1);
        #1 Reset = 1'b1;
        #1;
        checkOutput("t5 strobe in reset", {31'd0, Set_Minutes}, 0);
        checkOutput("t5 repeat in reset", {30'd0, Repeat_Active}, 0);
        nextEdge(3);
        Reset = 1'b0;
        startTest();
        nextEdge(30);
        checkOutput("t5 held no strobe", qMin.size(), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        nextEdge(12);
        startTest();
        applyStimulus(1'b1, 1'b0, 1'b1);
        nextEdge(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        toRel(20);
        checkOutput("t5 re-press count", qMin.size(), 1);
        checkOutput("t5 re-press edge", qAt(qMin, 0), 7);

        // 6: set mode off while held, then on while still held.
        $display("[TB] test 6: set enable gating");
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextEdge(4);
        startTest();
        applyStimulus(1'b0, 1'b1, 1'b0);
        nextEdge(30);
        checkOutput("t6 disabled count", qHr.size(), 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        nextEdge(30);
        checkOutput("t6 enabled held count", qHr.size(), 0);
        checkOutput("t6 enabled held repeat", {31'd0, repeatSeen}, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        nextEdge(12);
        startTest();
        applyStimulus(1'b0, 1'b1, 1'b1);
`ifdef TIME_SET_ACCEL_EN
        toRel(100);
        applyStimulus(1'b0, 1'b0, 1'b1);
        toRel(110);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("t6 accel pulse %0d", k), qAt(qHr, k), expHr6[k]);
        end
`else
        nextEdge(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        toRel(20);
        checkOutput("t6 re-press count", qHr.size(), 1);
        checkOutput("t6 re-press edge", qAt(qHr, 0), expHr6[0]);
`endif

        checkOutput("never simultaneous", {31'd0, collisionSeen}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
